store_bus_monitor: RTL
======================

Name: store_bus_monitor

Overview:
- Sits directly downstream of the multicycle MIPS `top`.
- Consumes its data-memory bus (memwrite, dataadr, writedata) every cycle.
- Captures each store into a show-ahead trace FIFO, drained over a valid/ready port.
- Flags program completion on a programmable done-store signature, or a watchdog timeout if completion never arrives. Replaces ad-hoc pass checks in benches and FPGA debug.

Parameters:
DEPTH, 8, trace FIFO entries (power of two, >=2)
DONE_ADDR, 32'h0000004C, store address of the completion signature
DONE_DATA, 32'h00000005, store data of the completion signature
TIMEOUT, 2000, watchdog limit in clk cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
memwrite  in  1  store strobe from top, 1 cycle per store
dataadr  in  32  store address from top
writedata  in  32  store data from top
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid&out_ready
out_addr  out  32  head address; 0 when out_valid=0
out_data  out  32  head data; 0 when out_valid=0
level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a store was dropped because FIFO full
store_cnt  out  16  stores seen in RUN, saturates at 16'hFFFF
done  out  1  sticky: completion signature seen
timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (reset=0, async): FSM=RUN; FIFO empty; level=0; out_valid=0; out_addr=out_data=0; overflow=0; store_cnt=0; done=0; timeout=0; watchdog=0. Outputs reach these values without waiting for a clk edge.
- FSM states: RUN, DONE, TIMEOUT. Both DONE and TIMEOUT are absorbing and are left only by reset.
- RUN, on each clk edge:
  - Watchdog increments.
  - If memwrite=1: store_cnt++ (saturating); push {dataadr, writedata}.
  - If memwrite=1 and dataadr==DONE_ADDR and writedata==DONE_DATA: next state DONE, done=1. The matching store is itself pushed.
  - Else if TIMEOUT!=0 and watchdog==TIMEOUT-1: next state TIMEOUT, timeout=1. The timeout flag rises on the TIMEOUT-th edge after reset release.
  - Same-edge match and expiry: DONE wins; timeout stays 0.
- DONE/TIMEOUT: memwrite ignored; no push; store_cnt and watchdog frozen. FIFO keeps draining.
- FIFO:
  - Show-ahead: out_addr/out_data present the oldest entry combinationally from storage while out_valid=1.
  - Pop on out_valid&out_ready at the clk edge.
  - Push when full and no pop in the same cycle: entry dropped, overflow set, store_cnt still counts.
  - Push and pop when full, same cycle: both occur; level unchanged; no overflow.
  - Push and pop when empty: only the push occurs; out_valid=1 on the next cycle. No combinational bypass.
  - Pointers wrap modulo DEPTH. level = pushes − pops, range 0..DEPTH.
  - out_ready while out_valid=0: no effect.
- Latency: a store on edge N is visible at the head on edge N+1 if the FIFO was empty.
- Reset asserted mid-operation: all state cleared immediately; in-flight FIFO contents are lost.
- Comparisons are full 32-bit equality. No X filtering is required.

Test Plan:
- Reset mid-run: reset=0 at an arbitrary cycle with FIFO non-empty -> all outputs at reset values immediately; after release, FSM=RUN and level=0.
- Single store, ready held 1: memwrite=1 at 0x10/0x7 -> next cycle out_valid=1, out_addr=0x10, out_data=7; after one more edge out_valid=0, store_cnt=1.
- Overflow and full push+pop: out_ready=0, 9 stores with DEPTH=8 -> level=8, overflow=1, store_cnt=9, head = first store. Then one cycle with store + out_ready=1 -> level stays 8, overflow unchanged.
- Done signature: stores 0x20/1, then 0x4C/5, then 0x50/9 -> done=1 after the 0x4C store; trace drains 0x20, 0x4C then empties; 0x50 not captured; store_cnt=2.
- Watchdog: TIMEOUT=16, no stores -> timeout=1 exactly 16 edges after release; a later 0x4C/5 store leaves done=0. With TIMEOUT=16 and a 0x4C/5 store on the 16th edge -> done=1, timeout=0.
- Wrap-around: DEPTH=8, 20 stores with out_ready toggling every cycle -> all 20 emerge in order with correct addr/data; overflow=0; level returns to 0.

Source files
------------

// File: rtl/store_bus_monitor_if.sv
// rtl/store_bus_monitor_if.sv - data-memory store bus in, trace drain and status out
// master = MIPS top plus trace consumer, slave = the monitor
interface store_bus_monitor_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            memwrite;
  logic [31:0]     dataadr;
  logic [31:0]     writedata;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_addr;
  logic [31:0]     out_data;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [15:0]     store_cnt;
  logic            done;
  logic            timeout;

  modport master (
    output memwrite, dataadr, writedata, out_ready,
    input  out_valid, out_addr, out_data, level, overflow, store_cnt, done, timeout
  );

  modport slave (
    input  memwrite, dataadr, writedata, out_ready,
    output out_valid, out_addr, out_data, level, overflow, store_cnt, done, timeout
  );
endinterface

// File: rtl/store_bus_monitor.sv
// rtl/store_bus_monitor.sv - store trace FIFO with done-signature and watchdog detection
// Stores are traced only while RUN; DONE and TIMEOUT are absorbing until reset.
module store_bus_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DONE_ADDR = 32'h0000004C,
  parameter logic [31:0] DONE_DATA = 32'h00000005,
  parameter int unsigned TIMEOUT   = 2000
) (
  input  logic               clk,
  input  logic               reset,
  store_bus_monitor_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [31:0] WD_LAST  = TIMEOUT - 32'd1;
  localparam bit          WD_EN    = (TIMEOUT != 0);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_DONE    = 2'd1;
  localparam logic [1:0] S_TIMEOUT = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic [15:0]   r_store_cnt;
  logic [31:0]   r_wdog;

  logic w_run;
  logic w_store;
  logic w_match;
  logic w_expire;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_run    = (r_state == S_RUN);
  assign w_store  = w_run && bus.memwrite;
  assign w_match  = (bus.dataadr == DONE_ADDR) && (bus.writedata == DONE_DATA);
  assign w_expire = WD_EN && (r_wdog == WD_LAST);
  assign w_valid  = (r_level != '0);
  assign w_full   = (r_level == FULL_LVL);
  assign w_pop    = w_valid && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push   = w_store && (!w_full || w_pop);
  assign w_drop   = w_store && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
    end else if (r_state == S_RUN) begin
      if (w_store && w_match) begin
        r_state <= S_DONE;
      end else if (w_expire) begin
        r_state <= S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog      <= '0;
      r_store_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_run) begin
        r_wdog <= r_wdog + 32'd1;
      end
      if (w_store && (r_store_cnt != 16'hFFFF)) begin
        r_store_cnt <= r_store_cnt + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and level only.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= bus.dataadr;
      r_mem_data[r_wr_ptr] <= bus.writedata;
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_addr  = w_valid ? r_mem_addr[r_rd_ptr] : 32'd0;
  assign bus.out_data  = w_valid ? r_mem_data[r_rd_ptr] : 32'd0;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
  assign bus.store_cnt = r_store_cnt;
  assign bus.done      = (r_state == S_DONE);
  assign bus.timeout   = (r_state == S_TIMEOUT);
endmodule
